card_request_initiator: RTL and testbench
=========================================

Name: card_request_initiator

Overview:
- Initiator side of the card-request handshake. The game FSM asks for a card here.
- This block drives req_card_o toward the seed_random control path and waits for that path's registered SEND state.
- It samples the random datapath value and turns it into a validated card rank (1..13) and blackjack points.
- It owns retry (rejection sampling), timeout and handshake release, so the game FSM sees a single clean card_valid_o pulse.

Parameters:
- RND_W, 8, width of rnd_data_i; must be >= 4; only bits [3:0] are used.
- TIMEOUT_CYC, 64, max cycles spent in REQ before abort; must be >= 4.
- CNT_W, 7, width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT_CYC.

Ports:
- clk_cr_i  input  1  clock, rising edge.
- rst_cr_i  input  1  asynchronous active-low reset.
- draw_i  input  1  request one card; level sampled in IDLE only.
- state_i  input  1  SEND state from the seed control path (1 = SEND, 0 = IDLE).
- rnd_data_i  input  RND_W  random value from the seed datapath; valid while state_i = 1.
- req_card_o  output  1  card request to the seed control path (req_card_state).
- busy_o  output  1  high in any state except IDLE.
- card_valid_o  output  1  one-cycle pulse; card_rank_o/card_points_o are new.
- card_rank_o  output  4  1 = A, 2..10, 11 = J, 12 = Q, 13 = K; holds its value between draws.
- card_points_o  output  5  A = 11, 2..10 = face value, J/Q/K = 10.
- timeout_err_o  output  1  one-cycle pulse on abort.

Behaviour:
- All outputs are registered. Under reset: state = IDLE and every output = 0 (rank and points 0); the timeout counter is cleared.
- Reset asserted mid-transaction aborts immediately. No valid or error pulse is produced; the seed path sees req_card_o = 0.
- FSM states: IDLE, REQ, RELEASE.
- IDLE:
  - req_card_o = 0, busy_o = 0.
  - draw_i = 1 -> REQ, and clear the counter.
- REQ:
  - req_card_o = 1, busy_o = 1; the counter increments every cycle.
  - If state_i = 1, let n = rnd_data_i[3:0].
    - n <= 12: latch rank = n+1 and the matching points, pulse card_valid_o, go to RELEASE.
    - n >= 13: reject and stay in REQ; resample the next cycle with req_card_o still high.
  - If the counter reaches TIMEOUT_CYC-1 with no accepted card: pulse timeout_err_o, go to RELEASE, and leave rank and points unchanged.
  - If acceptance and timeout fall in the same cycle, acceptance wins and no error is raised.
- RELEASE:
  - req_card_o = 0, busy_o = 1.
  - Stay until state_i = 0, then go to IDLE. This guarantees the responder has returned to IDLE before any new request.
- draw_i while busy is ignored, not queued. A draw_i held high continuously produces back-to-back transactions.
- Nominal latency, with draw_i sampled at edge 0:
  - req_card_o high in cycle 1.
  - state_i high in cycle 2; sampled at the end of cycle 2.
  - card_valid_o high in cycle 3.
  - state_i low in cycle 4.
  - IDLE in cycle 5.
  - Each rejection adds 1 cycle.
- state_i = 1 while in IDLE is ignored; a stale responder is not an error.

Optional Feature:
- Macro: CARD_DECK_TRACK_EN.
- With the macro defined:
  - Single 52-card deck tracking, with 13 3-bit used-counters (0..4) reset to 0.
  - Added ports: shuffle_i (input 1) and deck_empty_o (output 1).
  - In REQ, a candidate n <= 12 whose rank counter = 4 is also rejected.
  - On acceptance, that rank counter increments.
  - deck_empty_o = 1 when all counters = 4. While it is high, draw_i in IDLE is ignored.
  - shuffle_i clears all counters, in IDLE only.
  - A timeout clears nothing.
- Without the macro: no tracking, the extra ports are absent, and ranks may repeat without limit.

Test Plan:
- Reset then draw_i pulse; responder model echoes req one cycle late; rnd_data_i = 8'h04 -> card_valid_o in cycle 3, rank 5, points 5, timeout_err_o = 0, IDLE by cycle 5.
- rnd_data_i low nibble sequence 14, 13, 15, 0 -> three rejections, req_card_o held high, then rank 1 with points 11; valid 3 cycles later than nominal.
- rnd_data_i = 12 -> rank 13, points 10. Repeat with 10 -> rank 11, points 10; rank holds between draws.
- Responder never asserts state_i, TIMEOUT_CYC = 8 -> timeout_err_o pulses once after 8 REQ cycles, rank is unchanged, then IDLE (state_i = 0).
- Drive rst_cr_i low during REQ with state_i high -> all outputs 0 immediately; after release, a new draw completes normally.
- With CARD_DECK_TRACK_EN, drawing rank 7 four times leaves rnd = 6 rejected forever (ends in timeout). After 52 accepted cards, deck_empty_o = 1 and draw_i is ignored; shuffle_i clears deck_empty_o.

Source files
------------

// File: rtl/card_request_initiator.sv
// Card-request initiator: raises req_card_o toward the seed path, rejection-samples the random
// nibble into a rank 1..13 plus blackjack points. Optional deck tracking: CARD_DECK_TRACK_EN.
module card_request_initiator #(
    parameter int RND_W       = 8,
    parameter int TIMEOUT_CYC = 64,
    parameter int CNT_W       = 7
) (
    input  logic             clk_cr_i,
    input  logic             rst_cr_i,
    input  logic             draw_i,
    input  logic             state_i,
    input  logic [RND_W-1:0] rnd_data_i,
`ifdef CARD_DECK_TRACK_EN
    input  logic             shuffle_i,
    output logic             deck_empty_o,
`endif
    output logic             req_card_o,
    output logic             busy_o,
    output logic             card_valid_o,
    output logic [3:0]       card_rank_o,
    output logic [4:0]       card_points_o,
    output logic             timeout_err_o
);
    typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_RELEASE} state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             req_q, req_d;
    logic             busy_q, busy_d;
    logic             valid_q, valid_d;
    logic             err_q, err_d;
    logic [3:0]       rank_q, rank_d;
    logic [4:0]       points_q, points_d;

    logic [3:0]       nib;
    logic             cand_ok;
    logic             draw_ok;
    logic             accept;

    assign nib    = rnd_data_i[3:0];
    assign accept = (state_q == ST_REQ) && state_i && cand_ok;

    generate
        if (RND_W > 4) begin : g_rnd_hi
            logic unused_rnd_hi;
            assign unused_rnd_hi = ^rnd_data_i[RND_W-1:4];
        end
    endgenerate

    function automatic logic [4:0] rank_points(input logic [3:0] rank);
        if (rank == 4'd1) begin
            return 5'd11;
        end else if (rank >= 4'd11) begin
            return 5'd10;
        end else begin
            return {1'b0, rank};
        end
    endfunction

`ifdef CARD_DECK_TRACK_EN
    logic [2:0]  deck_cnt_q [13];
    logic [2:0]  deck_cnt_d [13];
    logic [15:0] rank_full;
    logic        deck_empty_q, deck_empty_d;

    // Nibbles 13..15 are padded as "full" so one lookup covers both rejection causes.
    generate
        for (genvar gi = 0; gi < 16; gi++) begin : g_full
            if (gi < 13) begin : g_rank
                assign rank_full[gi] = (deck_cnt_q[gi] == 3'd4);
            end else begin : g_pad
                assign rank_full[gi] = 1'b1;
            end
        end
    endgenerate

    assign cand_ok = (nib <= 4'd12) && !rank_full[nib];
    assign draw_ok = !deck_empty_q;

    always_comb begin
        deck_empty_d = 1'b1;
        for (int i = 0; i < 13; i++) begin
            deck_cnt_d[i] = deck_cnt_q[i];
            if ((state_q == ST_IDLE) && shuffle_i) begin
                deck_cnt_d[i] = 3'd0;
            end else if (accept && (nib == 4'(i))) begin
                deck_cnt_d[i] = deck_cnt_q[i] + 3'd1;
            end
            if (deck_cnt_d[i] != 3'd4) begin
                deck_empty_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_cr_i or negedge rst_cr_i) begin
        if (!rst_cr_i) begin
            for (int i = 0; i < 13; i++) begin
                deck_cnt_q[i] <= 3'd0;
            end
            deck_empty_q <= 1'b0;
        end else begin
            for (int i = 0; i < 13; i++) begin
                deck_cnt_q[i] <= deck_cnt_d[i];
            end
            deck_empty_q <= deck_empty_d;
        end
    end

    assign deck_empty_o = deck_empty_q;
`else
    assign cand_ok = (nib <= 4'd12);
    assign draw_ok = 1'b1;
`endif

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        valid_d  = 1'b0;
        err_d    = 1'b0;
        rank_d   = rank_q;
        points_d = points_q;
        unique case (state_q)
            ST_IDLE: begin
                if (draw_i && draw_ok) begin
                    state_d = ST_REQ;
                    cnt_d   = '0;
                end
            end
            ST_REQ: begin
                cnt_d = cnt_q + 1'b1;
                // Acceptance is tested first so it wins over a coincident timeout.
                if (accept) begin
                    rank_d   = nib + 4'd1;
                    points_d = rank_points(nib + 4'd1);
                    valid_d  = 1'b1;
                    state_d  = ST_RELEASE;
                end else if (cnt_q == CNT_LAST) begin
                    err_d   = 1'b1;
                    state_d = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                if (!state_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        req_d  = (state_d == ST_REQ);
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk_cr_i or negedge rst_cr_i) begin
        if (!rst_cr_i) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            req_q    <= 1'b0;
            busy_q   <= 1'b0;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
            rank_q   <= 4'd0;
            points_q <= 5'd0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            req_q    <= req_d;
            busy_q   <= busy_d;
            valid_q  <= valid_d;
            err_q    <= err_d;
            rank_q   <= rank_d;
            points_q <= points_d;
        end
    end

    assign req_card_o    = req_q;
    assign busy_o        = busy_q;
    assign card_valid_o  = valid_q;
    assign timeout_err_o = err_q;
    assign card_rank_o   = rank_q;
    assign card_points_o = points_q;
endmodule

// File: tb/tb_card_request_initiator.sv
// Bench for card_request_initiator: directed latency/timeout/reset cases plus randomized traffic
// against a transaction-level reference model compared on every falling clock edge.
module tb_card_request_initiator;
    localparam int RND_W = 8;
    localparam int TO    = 8;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic             draw_i = 1'b0;
    logic             state_i = 1'b0;
    logic [RND_W-1:0] rnd_data = '0;
    logic             req_card_o, busy_o, card_valid_o, timeout_err_o;
    logic [3:0]       card_rank_o;
    logic [4:0]       card_points_o;
`ifdef CARD_DECK_TRACK_EN
    logic             shuffle_i = 1'b0;
    logic             deck_empty_o;
`endif

    always #5 clk = ~clk;

    card_request_initiator #(.RND_W(RND_W), .TIMEOUT_CYC(TO), .CNT_W(CNT_W)) dut (
        .clk_cr_i      (clk),
        .rst_cr_i      (rst_n),
        .draw_i        (draw_i),
        .state_i       (state_i),
        .rnd_data_i    (rnd_data),
`ifdef CARD_DECK_TRACK_EN
        .shuffle_i     (shuffle_i),
        .deck_empty_o  (deck_empty_o),
`endif
        .req_card_o    (req_card_o),
        .busy_o        (busy_o),
        .card_valid_o  (card_valid_o),
        .card_rank_o   (card_rank_o),
        .card_points_o (card_points_o),
        .timeout_err_o (timeout_err_o)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int card_points(input int rank);
        if (rank == 1) return 11;
        if (rank > 10) return 10;
        return rank;
    endfunction

    // Reference model: a card request is open until a good sample arrives or TO request
    // cycles have elapsed; the block then stays busy until the responder drops state_i.
    bit m_open, m_busy, m_valid, m_err;
    int m_rank, m_points, m_req_cycles;
    int txn_id = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_open = 0; m_busy = 0; m_valid = 0; m_err = 0;
            m_rank = 0; m_points = 0; m_req_cycles = 0;
        end else begin
            m_valid = 0;
            m_err   = 0;
            if (m_open) begin
                m_req_cycles++;
                if (state_i && int'(rnd_data[3:0]) <= 12) begin
                    m_rank   = int'(rnd_data[3:0]) + 1;
                    m_points = card_points(m_rank);
                    m_valid  = 1;
                    m_open   = 0;
                end else if (m_req_cycles == TO) begin
                    m_err  = 1;
                    m_open = 0;
                end
            end else if (m_busy) begin
                if (!state_i) m_busy = 0;
            end else if (draw_i) begin
                m_open = 1;
                m_busy = 1;
                m_req_cycles = 0;
            end
        end
    end

    always @(negedge clk) begin
        check("req_card", int'(req_card_o), int'(m_open));
        check("busy", int'(busy_o), int'(m_busy));
        check("card_valid", int'(card_valid_o), int'(m_valid));
        check("timeout_err", int'(timeout_err_o), int'(m_err));
        check("card_rank", int'(card_rank_o), m_rank);
        check("card_points", int'(card_points_o), m_points);
        if (m_valid || m_err) begin
            txn_id++;
            $display("txn %0d: valid=%0d err=%0d rank=%0d points=%0d", txn_id,
                     card_valid_o, timeout_err_o, card_rank_o, card_points_o);
        end
    end

    // Responder: echoes req_card_o one cycle late, optionally silent or noisy.
    bit               silent = 0;
    int               noise_pct = 0;
    bit               last_req = 0;
    logic [RND_W-1:0] rnd_q[$];

    task automatic step();
        @(posedge clk);
        #1;
        if (silent) state_i = 1'b0;
        else if ($urandom_range(0, 99) < noise_pct) state_i = 1'($urandom_range(0, 1));
        else state_i = last_req;
        last_req = req_card_o;
        if (state_i && rnd_q.size() > 0) rnd_data = rnd_q.pop_front();
        else rnd_data = RND_W'($urandom_range(0, 255));
    endtask

    task automatic draw_txn(output int vcyc, output int ecyc, output int icyc);
        vcyc = 0; ecyc = 0; icyc = 0;
        draw_i = 1'b1;
        step();
        draw_i = 1'b0;
        for (int c = 1; c <= 40 && icyc == 0; c++) begin
            if (card_valid_o) vcyc = c;
            if (timeout_err_o) ecyc = c;
            if (!busy_o) icyc = c;
            if (icyc == 0) step();
        end
        if (icyc == 0) begin
            checks++;
            errors++;
            $display("FAIL txn_bound: still busy after 40 cycles, expected idle");
        end
    endtask

    initial begin
        int v, e, i;
        #1 rst_n = 1'b0;
        #3;
        check("rst_req", int'(req_card_o), 0);
        check("rst_busy", int'(busy_o), 0);
        check("rst_valid", int'(card_valid_o), 0);
        check("rst_err", int'(timeout_err_o), 0);
        check("rst_rank", int'(card_rank_o), 0);
        check("rst_points", int'(card_points_o), 0);
        repeat (2) step();
        rst_n = 1'b1;
        step();

        rnd_q.push_back(8'h04);
        draw_txn(v, e, i);
        check("nom_valid_cyc", v, 3);
        check("nom_err_cyc", e, 0);
        check("nom_idle_cyc", i, 5);
        check("nom_rank", int'(card_rank_o), 5);
        check("nom_points", int'(card_points_o), 5);

        rnd_q.push_back(8'hAE); rnd_q.push_back(8'h3D);
        rnd_q.push_back(8'hFF); rnd_q.push_back(8'h50);
        draw_txn(v, e, i);
        check("rej_valid_cyc", v, 6);
        check("rej_idle_cyc", i, 8);
        check("rej_rank", int'(card_rank_o), 1);
        check("rej_points", int'(card_points_o), 11);

        rnd_q.push_back(8'h0C);
        draw_txn(v, e, i);
        check("k_rank", int'(card_rank_o), 13);
        check("k_points", int'(card_points_o), 10);
        repeat (4) step();
        check("k_hold_rank", int'(card_rank_o), 13);
        rnd_q.push_back(8'h1A);
        draw_txn(v, e, i);
        check("j_rank", int'(card_rank_o), 11);
        check("j_points", int'(card_points_o), 10);

        silent = 1;
        draw_txn(v, e, i);
        silent = 0;
        check("to_err_cyc", e, TO + 1);
        check("to_valid_cyc", v, 0);
        check("to_idle_cyc", i, TO + 2);
        check("to_rank", int'(card_rank_o), 11);
        check("to_points", int'(card_points_o), 10);

        repeat (4) rnd_q.push_back(8'h0E);
        draw_i = 1'b1;
        step();
        draw_i = 1'b0;
        step();
        step();
        check("mid_req", int'(req_card_o), 1);
        check("mid_state_i", int'(state_i), 1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_req", int'(req_card_o), 0);
        check("arst_busy", int'(busy_o), 0);
        check("arst_rank", int'(card_rank_o), 0);
        check("arst_points", int'(card_points_o), 0);
        check("arst_valid", int'(card_valid_o), 0);
        check("arst_err", int'(timeout_err_o), 0);
        rnd_q.delete();
        last_req = 0;
        state_i = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();
        rnd_q.push_back(8'h07);
        draw_txn(v, e, i);
        check("post_rst_valid_cyc", v, 3);
        check("post_rst_rank", int'(card_rank_o), 8);
        check("post_rst_points", int'(card_points_o), 8);

        draw_i = 1'b1;
        repeat (200) step();
        noise_pct = 10;
        for (int c = 0; c < 3000; c++) begin
            if (c % 64 == 0) silent = ($urandom_range(0, 3) == 0);
            draw_i = ($urandom_range(0, 3) == 0);
            step();
        end
        draw_i = 1'b0;
        silent = 0;
        noise_pct = 0;
        for (int c = 0; c < 60 && busy_o; c++) step();
        if (busy_o) begin
            checks++;
            errors++;
            $display("FAIL drain_bound: busy_o=1 after drain, expected 0");
        end
        step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end
endmodule
